// File: rtl/icb_dma_master.sv
// icb_dma_master: single-outstanding ICB block mover between a 1-cycle-latency local SRAM and an ICB slave.
// Optional build macro ICB_DMA_ERR_ABORT_EN ends a block right after its first errored response.
module icb_dma_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LADDR_W = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               dir,
    input  logic [ADDR_W-1:0]  icb_base,
    input  logic [LADDR_W-1:0] loc_base,
    input  logic [LADDR_W-1:0] len,
    output logic               busy,
    output logic               done,
    output logic [LADDR_W-1:0] err_cnt,
    output logic               icb_cmd_valid,
    input  logic               icb_cmd_ready,
    output logic               icb_cmd_read,
    output logic [ADDR_W-1:0]  icb_cmd_addr,
    output logic [DATA_W-1:0]  icb_cmd_wdata,
    output logic [3:0]         icb_cmd_wmask,
    input  logic               icb_rsp_valid,
    output logic               icb_rsp_ready,
    input  logic [DATA_W-1:0]  icb_rsp_rdata,
    input  logic               icb_rsp_err,
    output logic               loc_rd_en,
    output logic [LADDR_W-1:0] loc_rd_addr,
    input  logic [DATA_W-1:0]  loc_rd_data,
    output logic               loc_wr_en,
    output logic [LADDR_W-1:0] loc_wr_addr,
    output logic [DATA_W-1:0]  loc_wr_data
);
    typedef enum logic [2:0] {IDLE, LRD, LAT, CMD, RSP, DONE} state_t;

    state_t             state, state_nxt;
    logic               dir_q;
    logic [ADDR_W-1:0]  icb_base_q;
    logic [LADDR_W-1:0] loc_base_q, len_q, idx, idx_inc;
    logic [DATA_W-1:0]  wdata_q;
    logic               rsp_fire, last_word, abort;

    assign idx_inc       = idx + 1'b1;
    assign last_word     = (idx_inc == len_q);
    assign rsp_fire      = (state == RSP) && icb_rsp_valid;
    assign icb_cmd_wmask = 4'hF;

`ifdef ICB_DMA_ERR_ABORT_EN
    // First error of the block: err_cnt is still zero when it arrives.
    assign abort = icb_rsp_err && (err_cnt == '0);
`else
    assign abort = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        busy          = (state != IDLE);
        done          = (state == DONE);
        icb_cmd_valid = 1'b0;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = '0;
        icb_cmd_wdata = '0;
        icb_rsp_ready = 1'b0;
        loc_rd_en     = 1'b0;
        loc_rd_addr   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) state_nxt = DONE;
                    else if (dir)  state_nxt = CMD;
                    else           state_nxt = LRD;
                end
            end
            LRD: begin
                loc_rd_en   = 1'b1;
                loc_rd_addr = loc_base_q + idx;
                state_nxt   = LAT;
            end
            LAT: state_nxt = CMD;
            CMD: begin
                // Fields come from registers only, so they hold steady while ready is low.
                icb_cmd_valid = 1'b1;
                icb_cmd_read  = dir_q;
                icb_cmd_addr  = icb_base_q + ADDR_W'({idx, 2'b00});
                icb_cmd_wdata = wdata_q;
                if (icb_cmd_ready) state_nxt = RSP;
            end
            RSP: begin
                icb_rsp_ready = 1'b1;
                if (icb_rsp_valid) begin
                    if (last_word || abort) state_nxt = DONE;
                    else if (dir_q)         state_nxt = CMD;
                    else                    state_nxt = LRD;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q       <= 1'b0;
            icb_base_q  <= '0;
            loc_base_q  <= '0;
            len_q       <= '0;
            idx         <= '0;
            err_cnt     <= '0;
            wdata_q     <= '0;
            loc_wr_en   <= 1'b0;
            loc_wr_addr <= '0;
            loc_wr_data <= '0;
        end else begin
            loc_wr_en <= 1'b0;
            if (state == IDLE && start) begin
                dir_q      <= dir;
                icb_base_q <= icb_base;
                loc_base_q <= loc_base;
                len_q      <= len;
                idx        <= '0;
                err_cnt    <= '0;
            end
            if (state == LAT) wdata_q <= loc_rd_data;
            if (rsp_fire) begin
                idx <= idx_inc;
                if (icb_rsp_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                if (dir_q && !abort) begin
                    loc_wr_en   <= 1'b1;
                    loc_wr_addr <= loc_base_q + idx;
                    loc_wr_data <= icb_rsp_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_icb_dma_master.sv
`timescale 1ns/1ps
// tb_icb_dma_master: table-driven transfers against a behavioural SRAM and ICB slave, with a
// command / local-write scoreboard plus hand-written sequences for ignored start and mid-transfer reset.
module tb_icb_dma_master;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int LADDR_W = 13;
`ifdef ICB_DMA_ERR_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    typedef struct packed {
        logic              read;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;
    typedef struct packed {
        logic [LADDR_W-1:0] addr;
        logic [DATA_W-1:0]  data;
    } lwr_t;
    typedef struct {
        string              name;
        logic               dir;
        logic [ADDR_W-1:0]  icb_base;
        logic [LADDR_W-1:0] loc_base;
        logic [LADDR_W-1:0] len;
        int                 stall;
        int                 rsp_delay;
        int                 err_word;
        int                 exp_cmds;
        int                 exp_errs;
        int                 exp_busy;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0, dir = 1'b0;
    logic [ADDR_W-1:0]  icb_base = '0;
    logic [LADDR_W-1:0] loc_base = '0, len = '0;
    logic               busy, done;
    logic [LADDR_W-1:0] err_cnt;
    logic               icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [ADDR_W-1:0]  icb_cmd_addr;
    logic [DATA_W-1:0]  icb_cmd_wdata;
    logic [3:0]         icb_cmd_wmask;
    logic               icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
    logic [DATA_W-1:0]  icb_rsp_rdata;
    logic               loc_rd_en, loc_wr_en;
    logic [LADDR_W-1:0] loc_rd_addr, loc_wr_addr;
    logic [DATA_W-1:0]  loc_rd_data, loc_wr_data;

    always #5 clk = ~clk;

    icb_dma_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LADDR_W(LADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .icb_base(icb_base),
        .loc_base(loc_base), .len(len), .busy(busy), .done(done), .err_cnt(err_cnt),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
        .icb_rsp_err(icb_rsp_err), .loc_rd_en(loc_rd_en), .loc_rd_addr(loc_rd_addr),
        .loc_rd_data(loc_rd_data), .loc_wr_en(loc_wr_en), .loc_wr_addr(loc_wr_addr),
        .loc_wr_data(loc_wr_data)
    );

    int   checks = 0, errors = 0;
    cmd_t exp_cmd_q[$];
    lwr_t exp_wr_q[$];
    logic [DATA_W-1:0] loc_mem [0:(1<<LADDR_W)-1];
    logic [DATA_W-1:0] slave_mem [logic [ADDR_W-1:0]];
    int cfg_stall = 0, cfg_rsp_delay = 0, cfg_err_word = -1, slave_idx = 0;
    int cmd_cnt = 0, wr_cnt = 0, rd_cnt = 0, busy_cnt = 0, done_cnt = 0, exp_wr_total = 0;
    vec_t tbl[7];
    vec_t v;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    function automatic logic [DATA_W-1:0] slave_read(input logic [ADDR_W-1:0] a);
        if (slave_mem.exists(a)) return slave_mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t mk(input string n, input logic d, input logic [ADDR_W-1:0] ib,
                                input int lb, input int ln, input int st, input int rd,
                                input int ew, input int ec, input int ee, input int eb);
        vec_t r;
        r.name = n; r.dir = d; r.icb_base = ib;
        r.loc_base = LADDR_W'(lb); r.len = LADDR_W'(ln);
        r.stall = st; r.rsp_delay = rd; r.err_word = ew;
        r.exp_cmds = ec; r.exp_errs = ee; r.exp_busy = eb;
        return r;
    endfunction

    // Local SRAM: one-cycle read latency.
    always @(posedge clk) begin
        if (loc_rd_en) loc_rd_data <= loc_mem[loc_rd_addr];
        if (loc_wr_en) loc_mem[loc_wr_addr] = loc_wr_data;
    end

    // ICB slave model and monitor: observe at negedge, drive just after posedge.
    initial begin : slave_mon
        bit cmd_hs, rsp_hs, hold_valid, pend, pend_err;
        int wait_cnt, rsp_cnt;
        logic [127:0] hold_fields;
        logic [DATA_W-1:0] pend_data;
        cmd_t hs_cmd, e;
        lwr_t w;
        hold_valid = 0; pend = 0; pend_err = 0; wait_cnt = 0; rsp_cnt = 0; pend_data = '0;
        icb_cmd_ready = 1'b0; icb_rsp_valid = 1'b0; icb_rsp_rdata = '0; icb_rsp_err = 1'b0;
        forever begin
            @(negedge clk);
            cmd_hs = icb_cmd_valid && icb_cmd_ready;
            rsp_hs = icb_rsp_valid && icb_rsp_ready;
            hs_cmd = {icb_cmd_read, icb_cmd_addr, icb_cmd_wdata};
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (rst_n) begin
                if (loc_rd_en) rd_cnt++;
                if (icb_cmd_valid) check("rsp_ready_low_in_cmd", icb_rsp_ready, 1'b0);
                if (hold_valid) begin
                    check("cmd_valid_held", icb_cmd_valid, 1'b1);
                    check("cmd_fields_held", {icb_cmd_read, icb_cmd_addr, icb_cmd_wdata}, hold_fields);
                end
                hold_valid  = icb_cmd_valid && !icb_cmd_ready;
                hold_fields = {icb_cmd_read, icb_cmd_addr, icb_cmd_wdata};
                if (cmd_hs) begin
                    cmd_cnt++;
                    check("cmd_wmask", icb_cmd_wmask, 4'hF);
                    checks++;
                    if (exp_cmd_q.size() == 0) begin
                        errors++;
                        $display("FAIL cmd_unexpected: actual addr %0h required no command", icb_cmd_addr);
                    end else begin
                        e = exp_cmd_q.pop_front();
                        check("cmd_read", hs_cmd.read, e.read);
                        check("cmd_addr", hs_cmd.addr, e.addr);
                        if (!e.read) check("cmd_wdata", hs_cmd.wdata, e.wdata);
                    end
                end
                if (loc_wr_en) begin
                    wr_cnt++;
                    checks++;
                    if (exp_wr_q.size() == 0) begin
                        errors++;
                        $display("FAIL loc_wr_unexpected: actual addr %0h required no write", loc_wr_addr);
                    end else begin
                        w = exp_wr_q.pop_front();
                        check("loc_wr_addr", loc_wr_addr, w.addr);
                        check("loc_wr_data", loc_wr_data, w.data);
                    end
                end
            end
            @(posedge clk); #1;
            if (!rst_n) begin
                pend = 0; hold_valid = 0; wait_cnt = 0;
                icb_cmd_ready = 1'b0; icb_rsp_valid = 1'b0; icb_rsp_err = 1'b0;
            end else begin
                if (rsp_hs) begin
                    pend = 0; icb_rsp_valid = 1'b0; icb_rsp_err = 1'b0;
                end
                if (cmd_hs) begin
                    pend      = 1;
                    rsp_cnt   = cfg_rsp_delay;
                    pend_data = hs_cmd.read ? slave_read(hs_cmd.addr) : 32'h0;
                    pend_err  = (slave_idx == cfg_err_word);
                    slave_idx++;
                end
                if (pend) begin
                    if (rsp_cnt == 0) begin
                        icb_rsp_valid = 1'b1; icb_rsp_rdata = pend_data; icb_rsp_err = pend_err;
                    end else begin
                        rsp_cnt--;
                    end
                end
                if (icb_cmd_valid) begin
                    icb_cmd_ready = (wait_cnt >= cfg_stall);
                    wait_cnt++;
                end else begin
                    icb_cmd_ready = 1'b0;
                    wait_cnt = 0;
                end
            end
        end
    end

    // Builds the expected command and local-write streams, then pulses start. Call at posedge+#1.
    task automatic start_xfer(input vec_t t);
        logic [ADDR_W-1:0]  a;
        logic [LADDR_W-1:0] la;
        bit   err;
        cmd_t c;
        lwr_t w;
        cmd_cnt = 0; wr_cnt = 0; rd_cnt = 0; busy_cnt = 0; done_cnt = 0; slave_idx = 0; exp_wr_total = 0;
        cfg_stall = t.stall; cfg_rsp_delay = t.rsp_delay; cfg_err_word = t.err_word;
        for (int i = 0; i < int'(t.len); i++) begin
            a   = t.icb_base + ADDR_W'(4 * i);
            la  = t.loc_base + LADDR_W'(i);
            err = (i == t.err_word);
            c.read = t.dir; c.addr = a; c.wdata = t.dir ? 32'h0 : loc_mem[la];
            exp_cmd_q.push_back(c);
            if (t.dir && !(ABORT && err)) begin
                w.addr = la; w.data = slave_read(a);
                exp_wr_q.push_back(w);
                exp_wr_total++;
            end
            if (ABORT && err) break;
        end
        start = 1'b1; dir = t.dir; icb_base = t.icb_base; loc_base = t.loc_base; len = t.len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_xfer(input vec_t t);
        bit seen = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            seen = done;
        end
        check({t.name, ":done_seen"}, seen, 1'b1);
        @(posedge clk); #1;
        check({t.name, ":busy_after_done"}, busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check({t.name, ":done_pulses"}, done_cnt, 1);
        check({t.name, ":cmd_count"}, cmd_cnt, t.exp_cmds);
        check({t.name, ":loc_rd_count"}, rd_cnt, t.dir ? 0 : t.exp_cmds);
        check({t.name, ":loc_wr_count"}, wr_cnt, exp_wr_total);
        check({t.name, ":err_cnt"}, err_cnt, t.exp_errs);
        check({t.name, ":cmd_q_left"}, exp_cmd_q.size(), 0);
        check({t.name, ":wr_q_left"}, exp_wr_q.size(), 0);
        if (t.exp_busy >= 0) check({t.name, ":busy_cycles"}, busy_cnt, t.exp_busy);
        exp_cmd_q.delete();
        exp_wr_q.delete();
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: actual time limit reached, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        for (int i = 0; i < (1 << LADDR_W); i++) loc_mem[i] = 32'hA000_0000 | i;
        loc_mem[5] = 32'd11; loc_mem[6] = 32'd22; loc_mem[7] = 32'd33;
        slave_mem[32'h1000_8000] = 32'hAAAA_5555;
        slave_mem[32'h1000_8004] = 32'h1234_5678;

        tbl[0] = mk("wr_len3",     1'b0, 32'h1000_0000, 5,    3, 0, 0, -1, 3,              0, 13);
        tbl[1] = mk("rd_len2",     1'b1, 32'h1000_8000, 100,  2, 0, 3, -1, 2,              0, 11);
        tbl[2] = mk("wr_stall5",   1'b0, 32'h2000_0000, 20,   2, 5, 1, -1, 2,              0, 21);
        tbl[3] = mk("len0",        1'b0, 32'h3000_0000, 7,    0, 0, 0, -1, 0,              0, 1);
        tbl[4] = mk("wr_err_w1",   1'b0, 32'h3000_0000, 40,   4, 0, 0, 1,  ABORT ? 2 : 4,  1, -1);
        tbl[5] = mk("rd_err_wrap", 1'b1, 32'hFFFF_FFF8, 8190, 4, 2, 1, 2,  ABORT ? 3 : 4,  1, -1);
        tbl[6] = mk("rd_len1",     1'b1, 32'h0000_0040, 0,    1, 0, 0, -1, 1,              0, 3);

        repeat (3) @(negedge clk);
        check("reset:ctrl", {busy, done, err_cnt, icb_cmd_valid, icb_cmd_read, icb_rsp_ready,
                             loc_rd_en, loc_wr_en}, 0);
        check("reset:buses", {icb_cmd_addr, icb_cmd_wdata, loc_rd_addr, loc_wr_addr}, 0);
        check("reset:wmask", icb_cmd_wmask, 4'hF);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) begin
            start_xfer(tbl[k]);
            finish_xfer(tbl[k]);
        end

        // start while busy must not disturb the running block
        v = mk("wr_ignore_start", 1'b0, 32'h4000_0000, 60, 4, 0, 0, -1, 4, 0, 17);
        start_xfer(v);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; dir = 1'b1; len = 13'd1; icb_base = 32'hDEAD_0000; loc_base = '0;
        @(posedge clk); #1;
        start = 1'b0;
        finish_xfer(v);

        // asynchronous reset while waiting on the response of word 2
        v = mk("rd_reset_mid", 1'b1, 32'h5000_0000, 200, 4, 0, 3, -1, 0, 0, -1);
        start_xfer(v);
        begin : wait_rsp2
            bit hit = 0;
            for (int c = 0; c < 500 && !hit; c++) begin
                @(negedge clk); #1;
                hit = (cmd_cnt == 3) && icb_rsp_ready;
            end
            check("reset_mid:reached_rsp2", hit, 1'b1);
        end
        check("reset_mid:writes_before", wr_cnt, 2);
        #1 rst_n = 1'b0;
        #1;
        check("reset_async:ctrl", {busy, done, err_cnt, icb_cmd_valid, icb_cmd_read, icb_rsp_ready,
                                   loc_rd_en, loc_wr_en}, 0);
        check("reset_async:cmd_bus", {icb_cmd_addr, icb_cmd_wdata}, 0);
        check("reset_async:loc_bus", {loc_rd_addr, loc_wr_addr, loc_wr_data}, 0);
        repeat (3) @(negedge clk);
        check("reset_mid:no_done", done_cnt, 0);
        exp_cmd_q.delete();
        exp_wr_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        v = mk("rd_after_reset", 1'b1, 32'h5000_0000, 200, 2, 0, 0, -1, 2, 0, 5);
        start_xfer(v);
        finish_xfer(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
